// File: rtl/seq_matrix_multiplier.sv
// rtl/seq_matrix_multiplier.sv - sequential NxN unsigned matrix multiplier, C = A*B or C += A*B
// Each A*B element product is built bit-serially, one partial product per clock.
module seq_matrix_multiplier #(
  parameter int N  = 3,
  parameter int DW = 16,
  parameter int IW = ($clog2(N) > 1) ? $clog2(N) : 1,
  parameter int CW = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [IW-1:0] wr_row,
  input  logic [IW-1:0] wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          acc_mode,
  output logic          busy,
  output logic          done,
  input  logic [IW-1:0] rd_row,
  input  logic [IW-1:0] rd_col,
  output logic [CW-1:0] rd_data
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int PW = 2*DW;
  localparam logic [IW:0]   N_EXT    = (IW+1)'(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW-1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DW-1:0] a_mem_q [N][N];
  logic [DW-1:0] a_mem_d [N][N];
  logic [DW-1:0] b_mem_q [N][N];
  logic [DW-1:0] b_mem_d [N][N];
  logic [CW-1:0] c_mem_q [N][N];
  logic [CW-1:0] c_mem_d [N][N];

  logic [PW-1:0] prod_q, prod_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] rd_data_q, rd_data_d;

  logic wr_ok, rd_ok;
  logic i_last, j_last, k_last, bit_last, all_last;

  assign wr_ok    = wr_en && (state_q == S_IDLE) &&
                    ({1'b0, wr_row} < N_EXT) && ({1'b0, wr_col} < N_EXT);
  assign rd_ok    = ({1'b0, rd_row} < N_EXT) && ({1'b0, rd_col} < N_EXT);
  assign i_last   = (i_q == IDX_LAST);
  assign j_last   = (j_q == IDX_LAST);
  assign k_last   = (k_q == IDX_LAST);
  assign bit_last = (bit_q == BIT_LAST);
  assign all_last = i_last && j_last && k_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MUL;
      S_MUL:   if (bit_last) state_d = S_ACC;
      S_ACC:   state_d = all_last ? S_DONE : S_MUL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_MUL) || (state_q == S_ACC);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_mem_d   = a_mem_q;
    b_mem_d   = b_mem_q;
    c_mem_d   = c_mem_q;
    prod_d    = prod_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    bit_d     = bit_q;
    acc_d     = acc_q;
    rd_data_d = rd_ok ? c_mem_q[rd_row][rd_col] : '0;

    if (wr_ok) begin
      if (wr_sel) b_mem_d[wr_row][wr_col] = wr_data;
      else        a_mem_d[wr_row][wr_col] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d  = acc_mode;
          i_d    = '0;
          j_d    = '0;
          k_d    = '0;
          bit_d  = '0;
          prod_d = '0;
        end
      end
      S_MUL: begin
        if (a_mem_q[i_q][k_q][bit_q]) begin
          prod_d = prod_q + (PW'(b_mem_q[k_q][j_q]) << bit_q);
        end
        bit_d = bit_last ? '0 : bit_q + BW'(1);
      end
      S_ACC: begin
        // The first k term overwrites C unless this run accumulates onto old C.
        if ((k_q == '0) && !acc_q) begin
          c_mem_d[i_q][j_q] = CW'(prod_q);
        end else begin
          c_mem_d[i_q][j_q] = c_mem_q[i_q][j_q] + CW'(prod_q);
        end
        prod_d = '0;
        bit_d  = '0;
        if (!k_last) begin
          k_d = k_q + IW'(1);
        end else begin
          k_d = '0;
          if (!j_last) begin
            j_d = j_q + IW'(1);
          end else begin
            j_d = '0;
            i_d = i_last ? '0 : i_q + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem_q[r][c] <= '0;
          b_mem_q[r][c] <= '0;
          c_mem_q[r][c] <= '0;
        end
      end
      prod_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      bit_q     <= '0;
      acc_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      a_mem_q   <= a_mem_d;
      b_mem_q   <= b_mem_d;
      c_mem_q   <= c_mem_d;
      prod_q    <= prod_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      bit_q     <= bit_d;
      acc_q     <= acc_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
